// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage PC owner arbitrating halt/redirect/stall/sequential fetch, with drain-then-halt.
// Define FETCH_STAT_EN to add saturating fetch/bubble statistics counters.
module fetch_sequencer #(
    parameter int                  ADDR_BIT     = 10,
    parameter logic [ADDR_BIT-1:0] RESET_PC     = '0,
    parameter int                  DRAIN_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_BIT-1:0] redirect_pc,
    input  logic                halt,
    input  logic                resume,
    output logic [ADDR_BIT-1:0] pc,
    output logic                fetch_valid,
    output logic                flush,
    output logic                halted,
    output logic [31:0]         dbg_pc
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]         stat_fetch,
    output logic [31:0]         stat_bubble
`endif
);
    localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2;
    logic [1:0]          state, next_state;
    logic [3:0]          cnt, next_cnt;
    logic [ADDR_BIT-1:0] next_pc;
    logic                next_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            pc     <= RESET_PC;
            cnt    <= '0;
            halted <= 1'b0;
        end else begin
            state  <= next_state;
            pc     <= next_pc;
            cnt    <= next_cnt;
            halted <= next_halted;
        end
    end

    always_comb begin
        next_state  = state;
        next_pc     = pc;
        next_cnt    = cnt;
        next_halted = halted;
        case (state)
            RUN: begin
                if (halt) begin
                    next_state = DRAIN;
                    next_cnt   = 4'(DRAIN_CYCLES);
                end else if (redirect) next_pc = redirect_pc;
                else if (!stall) next_pc = pc + 1'b1;
            end
            DRAIN: begin
                next_cnt = cnt - 1'b1;
                if (cnt == 4'd1) begin
                    next_state  = HALT;
                    next_halted = 1'b1;
                end
            end
            HALT: begin
                if (resume) begin
                    next_state  = RUN;
                    next_halted = 1'b0;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // rst_n gates the strobes so nothing is fetched or flushed while reset is held
    always_comb begin
        fetch_valid = rst_n && state == RUN && !halt && !redirect && !stall;
        flush       = rst_n && (state != RUN || halt || redirect);
        dbg_pc      = {{(30-ADDR_BIT){1'b0}}, pc, 2'b00};
    end

`ifdef FETCH_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetch  <= '0;
            stat_bubble <= '0;
        end else if (state == RUN) begin
            if (fetch_valid && stat_fetch != '1) stat_fetch <= stat_fetch + 1'b1;
            if ((stall || flush) && stat_bubble != '1) stat_bubble <= stat_bubble + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer sequencing, redirect, drain/halt/resume and reset.
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, stall, redirect, halt, resume;
    logic [9:0] redirect_pc, pc;
    logic       fetch_valid, flush, halted;
    logic [31:0] dbg_pc;
`ifdef FETCH_STAT_EN
    logic [31:0] stat_fetch, stat_bubble;
`endif
    int n_chk = 0, n_pass = 0;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .resume(resume), .pc(pc), .fetch_valid(fetch_valid), .flush(flush),
        .halted(halted), .dbg_pc(dbg_pc)
`ifdef FETCH_STAT_EN
        , .stat_fetch(stat_fetch), .stat_bubble(stat_bubble)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // advance one edge, then settle inputs/outputs away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [9:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        tick();
        redirect = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; resume = 1'b0; redirect_pc = '0;
        tick(); tick();
        #1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_fv", 32'(fetch_valid), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_dbg", dbg_pc, 0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("seq_pc", 32'(pc), 32'(i));
            chk("seq_fv", 32'(fetch_valid), 1);
            chk("seq_flush", 32'(flush), 0);
            tick();
        end
        // wrap at top of address space
        redirect = 1'b1; redirect_pc = 10'h3FF;
        #1;
        chk("redir_flush", 32'(flush), 1);
        chk("redir_fv", 32'(fetch_valid), 0);
        tick();
        redirect = 1'b0;
        #1;
        chk("wrap_pc_top", 32'(pc), 32'h3FF);
        chk("wrap_dbg_top", dbg_pc, 32'h0000_0FFC);
        chk("wrap_fv", 32'(fetch_valid), 1);
        tick();
        chk("wrap_pc", 32'(pc), 0);
        chk("wrap_dbg", dbg_pc, 0);
        // stall with redirect overriding on its second cycle
        go_to(10'd5);
        stall = 1'b1;
        #1;
        chk("st1_pc", 32'(pc), 5);
        chk("st1_fv", 32'(fetch_valid), 0);
        chk("st1_flush", 32'(flush), 0);
        tick();
        redirect = 1'b1; redirect_pc = 10'h40;
        #1;
        chk("st2_pc", 32'(pc), 5);
        chk("st2_flush", 32'(flush), 1);
        chk("st2_fv", 32'(fetch_valid), 0);
        tick();
        redirect = 1'b0;
        #1;
        chk("st3_pc", 32'(pc), 32'h40);
        chk("st3_flush", 32'(flush), 0);
        chk("st3_fv", 32'(fetch_valid), 0);
        tick();
        stall = 1'b0;
        #1;
        chk("st4_pc", 32'(pc), 32'h40);
        chk("st4_fv", 32'(fetch_valid), 1);
        tick();
        chk("st5_pc", 32'(pc), 32'h41);
        // halt, drain with ignored redirect/stall, then halt state
        go_to(10'd8);
        halt = 1'b1;
        #1;
        chk("h_flush", 32'(flush), 1);
        chk("h_fv", 32'(fetch_valid), 0);
        tick();
        halt = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 10'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dr_pc", 32'(pc), 8);
            chk("dr_flush", 32'(flush), 1);
            chk("dr_fv", 32'(fetch_valid), 0);
            chk("dr_halted", 32'(halted), 0);
            tick();
        end
        stall = 1'b0; halt = 1'b1;
        #1;
        chk("hl_halted", 32'(halted), 1);
        chk("hl_pc", 32'(pc), 8);
        chk("hl_flush", 32'(flush), 1);
        chk("hl_fv", 32'(fetch_valid), 0);
        tick();
        chk("hl2_halted", 32'(halted), 1);
        chk("hl2_pc", 32'(pc), 8);
        // resume (together with halt, which must be ignored)
        redirect = 1'b0; resume = 1'b1;
        #1;
        chk("res_fv", 32'(fetch_valid), 0);
        tick();
        resume = 1'b0; halt = 1'b0;
        #1;
        chk("res_halted", 32'(halted), 0);
        chk("res_fv1", 32'(fetch_valid), 1);
        chk("res_pc0", 32'(pc), 8);
        tick();
        chk("res_pc1", 32'(pc), 9);
        tick();
        chk("res_pc2", 32'(pc), 10);
        // async reset in the middle of DRAIN
        go_to(10'h20);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_pc", 32'(pc), 0);
        chk("mr_halted", 32'(halted), 0);
        chk("mr_fv", 32'(fetch_valid), 0);
        chk("mr_flush", 32'(flush), 0);
`ifdef FETCH_STAT_EN
        chk("mr_stat_fetch", stat_fetch, 0);
        chk("mr_stat_bubble", stat_bubble, 0);
`endif
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_run_pc", 32'(pc), 0);
        chk("mr_run_fv", 32'(fetch_valid), 1);
        chk("mr_run_flush", 32'(flush), 0);
        tick();
        chk("mr_run_pc1", 32'(pc), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
